// File: rtl/minibyte_pkg.sv
// Shared constants for the minibyte register block.
// Latency: n/a (constants only).
// Backpressure: n/a (no handshake in this block).
package minibyte_pkg;

  // Default data/address width of A, M, PC, IR and the main bus.
  localparam int MB_WIDTH = 8;

  // addr_mux_in encodings.
  localparam logic ADDR_SEL_PC = 1'b0;
  localparam logic ADDR_SEL_M  = 1'b1;

  // dbg_sel_in encodings for the debug readback mux.
  localparam logic [1:0] DBG_SEL_A  = 2'd0;
  localparam logic [1:0] DBG_SEL_M  = 2'd1;
  localparam logic [1:0] DBG_SEL_PC = 2'd2;
  localparam logic [1:0] DBG_SEL_IR = 2'd3;

endpackage

// File: rtl/minibyte_pc.sv
// Program counter: load, increment, hold, wrap pulse.
// Latency: 1 cycle from strobe to pc_out / wrap_out.
// Backpressure: none; the caller gates strobes (e.g. debug halt).
//
// Ports:
//   clk_in, rst_in    clock, synchronous active-high reset (PC <= PC_RST)
//   load_in           load PC from load_val_in (wins over inc_in)
//   inc_in            PC <= PC + 1 modulo 2^WIDTH
//   load_val_in       value loaded on load_in
//   pc_out            registered PC
//   wrap_out          one-cycle pulse after an increment from all-ones
module minibyte_pc
  import minibyte_pkg::*;
#(
  parameter int               WIDTH  = MB_WIDTH,
  parameter logic [WIDTH-1:0] PC_RST = '0
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             load_in,
  input  logic             inc_in,
  input  logic [WIDTH-1:0] load_val_in,
  output logic [WIDTH-1:0] pc_out,
  output logic             wrap_out
);

  localparam logic [WIDTH-1:0] PC_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] pc_d, pc_q;
  logic             wrap_d, wrap_q;

  always_comb begin
    pc_d   = pc_q;
    wrap_d = 1'b0;
    if (load_in) begin
      pc_d = load_val_in;
    end else if (inc_in) begin
      pc_d   = pc_q + PC_ONE;
      // The pulse marks the cycle in which PC has just rolled over to zero.
      wrap_d = &pc_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc_q   <= PC_RST;
      wrap_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      wrap_q <= wrap_d;
    end
  end

  assign pc_out   = pc_q;
  assign wrap_out = wrap_q;

endmodule

// File: rtl/minibyte_regfile.sv
// Architectural registers (A, M, PC, IR) for the minibyte CPU, driven by CU strobes.
// Latency: loads visible 1 cycle after the strobe; addr_out and flags are combinational.
// Backpressure: none; optional debug halt (MINIBYTE_DBG_EN) freezes all state.
//
// Ports:
//   clk_in, rst_in         clock, synchronous active-high reset
//   main_buss_in           ALU result bus, source of every load
//   set_a/m/pc/ir_in       load strobes; any combination allowed
//   inc_pc_in              PC increment (set_pc_in has priority)
//   addr_mux_in            ADDR_SEL_PC / ADDR_SEL_M select for addr_out
//   a/m/pc_out, ir_op_buss_out   register values
//   addr_out               memory address mux
//   alu_flag_z/n_out       flags from registered A
//   pc_wrap_out            one-cycle PC rollover pulse
//   dbg_halt_in, dbg_sel_in, dbg_data_out   only with MINIBYTE_DBG_EN defined
module minibyte_regfile
  import minibyte_pkg::*;
#(
  parameter int               WIDTH  = MB_WIDTH,
  parameter logic [WIDTH-1:0] PC_RST = '0
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] main_buss_in,
  input  logic             set_a_in,
  input  logic             set_m_in,
  input  logic             set_pc_in,
  input  logic             set_ir_in,
  input  logic             inc_pc_in,
  input  logic             addr_mux_in,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] m_out,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] ir_op_buss_out,
  output logic [WIDTH-1:0] addr_out,
  output logic             alu_flag_z_out,
  output logic             alu_flag_n_out,
`ifdef MINIBYTE_DBG_EN
  input  logic             dbg_halt_in,
  input  logic [1:0]       dbg_sel_in,
  output logic [WIDTH-1:0] dbg_data_out,
`endif
  output logic             pc_wrap_out
);

  // Single enable that gates every state change; reset bypasses it.
  logic run;
`ifdef MINIBYTE_DBG_EN
  assign run = ~dbg_halt_in;
`else
  assign run = 1'b1;
`endif

  logic [WIDTH-1:0] a_d, a_q;
  logic [WIDTH-1:0] m_d, m_q;
  logic [WIDTH-1:0] ir_d, ir_q;
  logic [WIDTH-1:0] pc_val;

  always_comb begin
    a_d  = a_q;
    m_d  = m_q;
    ir_d = ir_q;
    if (run && set_a_in)  a_d  = main_buss_in;
    if (run && set_m_in)  m_d  = main_buss_in;
    if (run && set_ir_in) ir_d = main_buss_in;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      a_q  <= '0;
      m_q  <= '0;
      ir_q <= '0;
    end else begin
      a_q  <= a_d;
      m_q  <= m_d;
      ir_q <= ir_d;
    end
  end

  minibyte_pc #(
    .WIDTH  (WIDTH),
    .PC_RST (PC_RST)
  ) u_pc (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .load_in     (run & set_pc_in),
    .inc_in      (run & inc_pc_in),
    .load_val_in (main_buss_in),
    .pc_out      (pc_val),
    .wrap_out    (pc_wrap_out)
  );

  assign a_out          = a_q;
  assign m_out          = m_q;
  assign pc_out         = pc_val;
  assign ir_op_buss_out = ir_q;

  assign addr_out = (addr_mux_in == ADDR_SEL_M) ? m_q : pc_val;

  // Flags look only at the registered A, never at the bus being loaded.
  assign alu_flag_z_out = (a_q == '0);
  assign alu_flag_n_out = a_q[WIDTH-1];

`ifdef MINIBYTE_DBG_EN
  always_comb begin
    dbg_data_out = a_q;
    case (dbg_sel_in)
      DBG_SEL_A:  dbg_data_out = a_q;
      DBG_SEL_M:  dbg_data_out = m_q;
      DBG_SEL_PC: dbg_data_out = pc_val;
      DBG_SEL_IR: dbg_data_out = ir_q;
      default:    dbg_data_out = a_q;
    endcase
  end
`endif

endmodule
